// File: rtl/wishbone_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single Wishbone master.
// Owns the master's start/addr/wdata inputs, returns done/err/rdata per port, aborts hung cycles.
module wishbone_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_read_i,
   input  logic        req0_write_i,
   input  logic [31:0] req0_addr_i,
   input  logic [63:0] req0_wdata_i,
   output logic        req0_done_o,
   output logic        req0_err_o,
   output logic [63:0] req0_rdata_o,
   input  logic        req1_read_i,
   input  logic        req1_write_i,
   input  logic [31:0] req1_addr_i,
   input  logic [63:0] req1_wdata_i,
   output logic        req1_done_o,
   output logic        req1_err_o,
   output logic [63:0] req1_rdata_o,
   input  logic        ack_i,
   input  logic [63:0] data_i,
   output logic        wbm_start_read_o,
   output logic        wbm_start_write_o,
   output logic [31:0] wbm_addr_o,
   output logic [63:0] wbm_wdata_o,
   output logic        wbm_rst_o,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] addr;
      logic [63:0] wdata;
   } req_t;

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   req_t              req [2];
   req_t              sel;
   state_t            state;
   logic              last;
   logic              owner;
   logic              op_read;
   logic              tmo;
   logic [15:0]       count;
   logic [1:0]        want;
   logic              pick;
   logic [1:0]        done;
   logic [1:0]        err;
   logic [1:0][63:0]  rdata;

   assign req[0] = {req0_read_i, req0_write_i, req0_addr_i, req0_wdata_i};
   assign req[1] = {req1_read_i, req1_write_i, req1_addr_i, req1_wdata_i};

   // On contention the port that did not win last time gets the bus.
   always_comb begin
      want[0] = req[0].read | req[0].write;
      want[1] = req[1].read | req[1].write;
      pick    = (want[0] & want[1]) ? ~last : want[1];
      sel     = req[pick];
   end

   // The master must be held in reset with the arbiter, so this path stays combinational.
   assign wbm_rst_o = rst_i | tmo;

   assign req0_done_o  = done[0];
   assign req1_done_o  = done[1];
   assign req0_err_o   = err[0];
   assign req1_err_o   = err[1];
   assign req0_rdata_o = rdata[0];
   assign req1_rdata_o = rdata[1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state             <= IDLE;
         last              <= 1'b1;
         owner             <= 1'b0;
         op_read           <= 1'b0;
         tmo               <= 1'b0;
         count             <= '0;
         grant_o           <= '0;
         wbm_start_read_o  <= 1'b0;
         wbm_start_write_o <= 1'b0;
         wbm_addr_o        <= '0;
         wbm_wdata_o       <= '0;
         done              <= '0;
         err               <= '0;
         rdata             <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         tmo  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|want) begin
                  // Read wins when a port raises both read and write.
                  owner             <= pick;
                  last              <= pick;
                  op_read           <= sel.read;
                  wbm_start_read_o  <= sel.read;
                  wbm_start_write_o <= ~sel.read;
                  wbm_addr_o        <= sel.addr;
                  wbm_wdata_o       <= sel.wdata;
                  grant_o           <= pick ? 2'b10 : 2'b01;
                  count             <= '0;
                  state             <= BUSY;
               end
            end
            BUSY: begin
               if (ack_i) begin
                  wbm_start_read_o  <= 1'b0;
                  wbm_start_write_o <= 1'b0;
                  done[owner]       <= 1'b1;
                  if (op_read)
                     rdata[owner] <= data_i;
                  state <= RELEASE;
               end else if (count == LIMIT) begin
                  wbm_start_read_o  <= 1'b0;
                  wbm_start_write_o <= 1'b0;
                  done[owner]       <= 1'b1;
                  err[owner]        <= 1'b1;
                  rdata[owner]      <= '1;
                  tmo               <= 1'b1;
                  state             <= RELEASE;
               end else begin
                  count <= count + 16'd1;
               end
            end
            RELEASE: begin
               // Master drops back to IDLE this cycle; requests are not sampled here.
               grant_o <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
